nunchuck_responder: RTL and testbench

- I2C target that emulates a Wii nunchuck at 7-bit address 0x52: the responder end of the link driven by nunchuckDriver.
- Serves a 6-byte report built from parallel input fields, so the nunchuck path and game logic can run in loopback, in simulation or on a second board pin pair, without a physical controller.
- Oversamples SCL/SDA on the system clock; drives SDA open-drain.

---
 rtl/nunchuck_responder.sv | 215 +++++++++++++++++++++
 tb/tb_nunchuck_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/nunchuck_responder.sv
// I2C target emulating a Wii nunchuck: serves a 6-byte report built from parallel inputs.
// SCL/SDA are oversampled on clkin, glitch-filtered, and SDA is driven open-drain.
module nunchuck_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h52,
  parameter int         FILT_LEN = 3
) (
  input  logic       clkin,
  input  logic       rst,
  input  logic       scl,
  inout  wire        sda,
  input  logic [7:0] stick_x,
  input  logic [7:0] stick_y,
  input  logic [9:0] accel_x,
  input  logic [9:0] accel_y,
  input  logic [9:0] accel_z,
  input  logic       z_btn,
  input  logic       c_btn,
  output logic       initialized,
  output logic       busy,
  output logic [7:0] reg_ptr,
  output logic       xfer_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_MACK, IGNORE
  } state_t;

  state_t state;

  logic [1:0]          scl_sync, sda_sync;
  logic [FILT_LEN-1:0] scl_hist, sda_hist;
  logic                scl_f, sda_f, scl_d, sda_d;
  logic                scl_rise, scl_fall, start_c, stop_c;

  logic [3:0]  bit_cnt;
  logic [7:0]  shreg;
  logic [7:0]  rx_byte;
  logic [7:0]  tx_byte;
  logic [47:0] report;
  logic [47:0] snap;
  logic [7:0]  reg_f0, reg_fb;
  logic        sda_low, rw, addr_hit, ptr_loaded, mack_ok;

  assign sda = sda_low ? 1'b0 : 1'bz;

  // Bus idles high, so the conditioning chain resets to 1 to avoid a false START.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_hist <= '1;
      sda_hist <= '1;
      scl_f    <= 1'b1;
      sda_f    <= 1'b1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda};
      scl_hist <= {scl_hist[FILT_LEN-2:0], scl_sync[1]};
      sda_hist <= {sda_hist[FILT_LEN-2:0], sda_sync[1]};
      if (&scl_hist)       scl_f <= 1'b1;
      else if (~|scl_hist) scl_f <= 1'b0;
      if (&sda_hist)       sda_f <= 1'b1;
      else if (~|sda_hist) sda_f <= 1'b0;
      scl_d <= scl_f;
      sda_d <= sda_f;
    end
  end

  assign scl_rise = scl_f & ~scl_d;
  assign scl_fall = ~scl_f & scl_d;
  assign start_c  = sda_d & ~sda_f & scl_f & scl_d;
  assign stop_c   = ~sda_d & sda_f & scl_f & scl_d;
  assign rx_byte  = {shreg[6:0], sda_f};

  assign report = {stick_x, stick_y, accel_x[9:2], accel_y[9:2], accel_z[9:2],
                   accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c_btn, ~z_btn};

  always_comb begin
    tx_byte = 8'hFF;
    if (initialized) begin
      case (reg_ptr)
        8'd0:    tx_byte = snap[47:40];
        8'd1:    tx_byte = snap[39:32];
        8'd2:    tx_byte = snap[31:24];
        8'd3:    tx_byte = snap[23:16];
        8'd4:    tx_byte = snap[15:8];
        8'd5:    tx_byte = snap[7:0];
        default: tx_byte = 8'hFF;
      endcase
    end
  end

  // In the ACK states sda_low doubles as the phase flag: first fall pulls low, second releases.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bit_cnt     <= 4'd0;
      shreg       <= 8'h00;
      snap        <= 48'h0;
      sda_low     <= 1'b0;
      rw          <= 1'b0;
      addr_hit    <= 1'b0;
      ptr_loaded  <= 1'b0;
      mack_ok     <= 1'b0;
      busy        <= 1'b0;
      xfer_done   <= 1'b0;
      reg_ptr     <= 8'h00;
      reg_f0      <= 8'h00;
      reg_fb      <= 8'hFF;
      initialized <= 1'b0;
    end else begin
      xfer_done   <= 1'b0;
      initialized <= (reg_f0 == 8'h55) && (reg_fb == 8'h00);
      if (start_c) begin
        state    <= ADDR;
        bit_cnt  <= 4'd0;
        sda_low  <= 1'b0;
        busy     <= 1'b1;
        addr_hit <= 1'b0;
      end else if (stop_c) begin
        state     <= IDLE;
        sda_low   <= 1'b0;
        busy      <= 1'b0;
        xfer_done <= addr_hit;
        addr_hit  <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              if (shreg[6:0] == DEV_ADDR) begin
                addr_hit   <= 1'b1;
                rw         <= sda_f;
                ptr_loaded <= 1'b0;
                if (sda_f) snap <= report;
                state <= ADDR_ACK;
              end else begin
                state <= IGNORE;
              end
            end
          end
          ADDR_ACK: if (scl_fall) begin
            if (!sda_low) begin
              sda_low <= 1'b1;
            end else if (rw) begin
              sda_low <= ~tx_byte[7];
              shreg   <= {tx_byte[6:0], 1'b0};
              bit_cnt <= 4'd1;
              state   <= RD_BYTE;
            end else begin
              sda_low <= 1'b0;
              bit_cnt <= 4'd0;
              state   <= WR_BYTE;
            end
          end
          WR_BYTE: if (scl_rise) begin
            shreg   <= rx_byte;
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd7) begin
              bit_cnt <= 4'd0;
              state   <= WR_ACK;
              if (!ptr_loaded) begin
                reg_ptr    <= rx_byte;
                ptr_loaded <= 1'b1;
              end else begin
                if (reg_ptr == 8'hF0) reg_f0 <= rx_byte;
                if (reg_ptr == 8'hFB) reg_fb <= rx_byte;
                reg_ptr <= reg_ptr + 8'd1;
              end
            end
          end
          WR_ACK: if (scl_fall) begin
            if (!sda_low) begin
              sda_low <= 1'b1;
            end else begin
              sda_low <= 1'b0;
              state   <= WR_BYTE;
            end
          end
          RD_BYTE: if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              sda_low <= 1'b0;
              mack_ok <= 1'b0;
              state   <= RD_MACK;
            end else begin
              sda_low <= ~shreg[7];
              shreg   <= {shreg[6:0], 1'b0};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end
          // Pointer advances on both ACK and NACK so it always names the next unread byte.
          RD_MACK: begin
            if (scl_rise) begin
              reg_ptr <= reg_ptr + 8'd1;
              if (sda_f) state <= IGNORE;
              else       mack_ok <= 1'b1;
            end else if (scl_fall && mack_ok) begin
              mack_ok <= 1'b0;
              sda_low <= ~tx_byte[7];
              shreg   <= {tx_byte[6:0], 1'b0};
              bit_cnt <= 4'd1;
              state   <= RD_BYTE;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nunchuck_responder.sv
// Directed bench for nunchuck_responder: bit-banged I2C initiator, read-data scoreboard.
module tb_nunchuck_responder;

  localparam int Q = 10;

  logic       clkin = 1'b0;
  logic       rst = 1'b0;
  logic       scl = 1'b1;
  logic       sda_drv = 1'b0;
  logic [7:0] stick_x = 8'h00, stick_y = 8'h00;
  logic [9:0] accel_x = 10'h0, accel_y = 10'h0, accel_z = 10'h0;
  logic       z_btn = 1'b0, c_btn = 1'b0;
  logic       initialized, busy, xfer_done;
  logic [7:0] reg_ptr;

  wire sda;
  pullup (sda);
  assign sda = sda_drv ? 1'b0 : 1'bz;

  int         n_assert = 0;
  int         n_fail = 0;
  int         xfer_cnt = 0;
  bit         exp_init = 1'b0;
  logic [7:0] exp_q[$];
  bit         ack;

  nunchuck_responder dut (
    .clkin(clkin), .rst(rst), .scl(scl), .sda(sda),
    .stick_x(stick_x), .stick_y(stick_y),
    .accel_x(accel_x), .accel_y(accel_y), .accel_z(accel_z),
    .z_btn(z_btn), .c_btn(c_btn),
    .initialized(initialized), .busy(busy), .reg_ptr(reg_ptr), .xfer_done(xfer_done)
  );

  always #10 clkin = ~clkin;

  always @(negedge clkin) if (xfer_done === 1'b1) xfer_cnt++;

  task automatic wq(input int n);
    repeat (n) @(negedge clkin);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model(input int idx);
    if (!exp_init || idx >= 6) return 8'hFF;
    case (idx)
      0: return stick_x;
      1: return stick_y;
      2: return accel_x[9:2];
      3: return accel_y[9:2];
      4: return accel_z[9:2];
      default: return {accel_z[1:0], accel_y[1:0], accel_x[1:0], ~c_btn, ~z_btn};
    endcase
  endfunction

  task automatic push_read(input int n, input int ptr);
    for (int i = 0; i < n; i++) exp_q.push_back(model(ptr + i));
  endtask

  task automatic wr_bit(input bit b);
    wq(Q); sda_drv = ~b;
    wq(Q); scl = 1'b1;
    wq(2*Q); scl = 1'b0;
  endtask

  task automatic rd_bit(output bit b);
    wq(Q); sda_drv = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q); b = sda;
    wq(Q); scl = 1'b0;
  endtask

  task automatic i2c_start;
    wq(Q); sda_drv = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q); sda_drv = 1'b1;
    wq(Q); scl = 1'b0;
  endtask

  task automatic i2c_stop;
    wq(Q); sda_drv = 1'b1;
    wq(Q); scl = 1'b1;
    wq(Q); sda_drv = 1'b0;
    wq(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output bit a);
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
  endtask

  task automatic rd_check(input bit nack, input string tag);
    logic [7:0] d;
    bit b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(nack);
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected none (scoreboard empty)", tag, d);
    end else begin
      check(tag, {8'h00, d}, {8'h00, exp_q.pop_front()});
    end
  endtask

  task automatic set_ptr(input logic [7:0] p, input string tag);
    i2c_start;
    wr_byte(8'hA4, ack); check({tag, "_addr_ack"}, ack, 0);
    wr_byte(p, ack);     check({tag, "_ptr_ack"}, ack, 0);
    i2c_stop;
  endtask

  initial begin
    logic [7:0] addr_w;

    wq(5);
    check("rst_sda", sda, 1);
    check("rst_busy", busy, 0);
    check("rst_ptr", reg_ptr, 8'h00);
    check("rst_init", initialized, 0);
    check("rst_xfer", xfer_done, 0);
    rst = 1'b1;
    wq(10);
    check("post_rst_busy", busy, 0);

    i2c_start;
    wq(2);
    check("busy_after_start", busy, 1);
    wr_byte(8'hA5, ack); check("uninit_addr_ack", ack, 0);
    push_read(6, 0);
    for (int i = 0; i < 6; i++) rd_check(i == 5, "uninit_byte");
    i2c_stop; wq(5);
    check("uninit_xfer", xfer_cnt, 1);

    i2c_start;
    wr_byte(8'hA4, ack); check("init1_addr_ack", ack, 0);
    wr_byte(8'hF0, ack); check("init1_reg_ack", ack, 0);
    wr_byte(8'h55, ack); check("init1_data_ack", ack, 0);
    i2c_stop; wq(5);
    check("init_half", initialized, 0);
    i2c_start;
    wr_byte(8'hA4, ack); check("init2_addr_ack", ack, 0);
    wr_byte(8'hFB, ack); check("init2_reg_ack", ack, 0);
    wr_byte(8'h00, ack); check("init2_data_ack", ack, 0);
    i2c_stop; wq(5);
    exp_init = 1'b1;
    check("init_done", initialized, 1);
    check("init_xfer", xfer_cnt, 3);

    stick_x = 8'h80; stick_y = 8'h7F;
    accel_x = 10'h201; accel_y = 10'h1FE; accel_z = 10'h3FF;
    z_btn = 1'b1; c_btn = 1'b0;
    set_ptr(8'h00, "rpt_ptr");
    i2c_start;
    wr_byte(8'hA5, ack); check("rpt_addr_ack", ack, 0);
    push_read(6, 0);
    for (int i = 0; i < 6; i++) rd_check(i == 5, "rpt_byte");
    i2c_stop; wq(5);
    check("rpt_ptr_end", reg_ptr, 8'h06);
    check("rpt_xfer", xfer_cnt, 5);

    stick_x = 8'h10;
    set_ptr(8'h00, "snap_ptr");
    i2c_start;
    wr_byte(8'hA5, ack); check("snap_addr_ack", ack, 0);
    push_read(3, 0);
    rd_check(0, "snap_b0");
    fork
      rd_check(0, "snap_b1");
      begin
        wq(12*Q);
        stick_x = 8'h20;
        accel_x = 10'h3C4;
      end
    join
    rd_check(1, "snap_b2");
    i2c_stop;
    set_ptr(8'h00, "snap2_ptr");
    i2c_start;
    wr_byte(8'hA5, ack); check("snap2_addr_ack", ack, 0);
    push_read(1, 0);
    rd_check(1, "snap_next_b0");
    i2c_stop; wq(5);
    check("snap_xfer", xfer_cnt, 9);

    i2c_start;
    wr_byte(8'hA6, ack); check("wrong_addr_nack", ack, 1);
    wr_byte(8'h00, ack); check("wrong_data_nack", ack, 1);
    i2c_stop; wq(5);
    check("wrong_ptr", reg_ptr, 8'h01);
    check("wrong_xfer", xfer_cnt, 9);

    accel_x = 10'h201;
    set_ptr(8'h00, "rs_ptr");
    i2c_start;
    wr_byte(8'hA5, ack); check("rs_addr_ack", ack, 0);
    push_read(2, 0);
    rd_check(0, "rs_b0");
    rd_check(0, "rs_b1");
    wq(Q); sda_drv = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q); check("rs_b2_msb", sda, 1);
    sda_drv = 1'b1;
    wq(Q); scl = 1'b0;
    wq(Q); sda_drv = 1'b0;
    wq(2); check("rs_release", sda, 1);
    wr_byte(8'hA4, ack); check("rs_new_addr_ack", ack, 0);
    wr_byte(8'h03, ack); check("rs_ptr_ack", ack, 0);
    i2c_stop; wq(5);
    check("rs_ptr", reg_ptr, 8'h03);
    check("rs_xfer", xfer_cnt, 11);

    addr_w = 8'hA4;
    i2c_start;
    for (int i = 7; i >= 0; i--) wr_bit(addr_w[i]);
    wq(Q); sda_drv = 1'b0;
    wq(Q); scl = 1'b1;
    wq(Q); check("ack_before_rst", sda, 0);
    rst = 1'b0;
    #1;
    check("rst_mid_ack_sda", sda, 1);
    check("rst_mid_ack_busy", busy, 0);
    check("rst_mid_ack_init", initialized, 0);
    check("rst_mid_ack_ptr", reg_ptr, 8'h00);
    wq(Q); scl = 1'b0;
    wq(Q); rst = 1'b1;
    wq(Q); scl = 1'b1;
    wq(2*Q);
    check("end_xfer", xfer_cnt, 11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
